// File: rtl/sseg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Front end for an eight-digit seven-segment display driver. A prescaler
// steps the digit index 0..7 once every DIV clock cycles. A 32-bit value is
// hex-encoded into active-high segment patterns for all eight digits, with a
// per-digit decimal point and optional leading-zero blanking.
//
// New display data is first captured into staging registers. It is copied
// into the display registers only at a frame boundary (the 7->0 wrap), or on
// the next edge when scanning is disabled. A frame therefore never shows a
// mix of old and new digits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; while low the prescaler and idx hold
//   load        one-cycle strobe that captures value/dp/lz_blank into staging
//   value[31:0] display value, digit k = value[4k+3:4k]
//   dp[7:0]     decimal-point mask, dp[k] lights the DP of digit k
//   lz_blank    leading-zero blanking enable
//   idx[3:0]    current digit index 0..7 (idx[3] is always 0)
//   seg0..seg7  segment pattern for digit k: {A,B,C,D,E,F,G,DP}
//   frame_done  one-cycle pulse in the cycle after each 7->0 wrap
//   pending     staged data is waiting to be committed to the display
//-----------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int DIV = 12500          // clock cycles per digit slot, >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic        lz_blank,
    output logic [3:0]  idx,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7,
    output logic        frame_done,
    output logic        pending
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
    localparam logic [2:0]     IDX_LAST = 3'd7;

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic          frame_done_q;
    logic          pending_q;

    // Staging copy, written by load.
    logic [31:0]   stg_value_q;
    logic [7:0]    stg_dp_q;
    logic          stg_lz_q;

    // Display copy, drives the encoder.
    logic [31:0]   disp_value_q;
    logic [7:0]    disp_dp_q;
    logic          disp_lz_q;

    //-------------------------------------------------------------------------
    // Control terms
    //-------------------------------------------------------------------------
    logic tick;
    logic wrap;
    logic commit;

    assign tick = en && (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == IDX_LAST);

    // With scanning stopped there is no frame to tear, so staged data is
    // committed on the very next edge instead of waiting for a wrap.
    assign commit = pending_q && (wrap || !en);

    //-------------------------------------------------------------------------
    // Prescaler and digit index
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the pre-edge values of its inputs; blocking here would
    // make results depend on statement order and create simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (en) begin
            if (tick) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;      // 7 -> 0 wraps naturally
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Registered from the wrap condition, so the pulse occupies the cycle
    // after the edge that moves idx from 7 to 0. tick already includes en,
    // so nothing pulses while scanning is stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= wrap;
        end
    end

    //-------------------------------------------------------------------------
    // Staging registers
    //-------------------------------------------------------------------------
    // NOTE: the staging and display registers are reset on purpose: the
    // display must come out of reset showing a defined pattern (all "0"
    // digits), and reset must discard any data still waiting for commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_value_q <= '0;
            stg_dp_q    <= '0;
            stg_lz_q    <= 1'b0;
        end else if (load) begin
            stg_value_q <= value;
            stg_dp_q    <= dp;
            stg_lz_q    <= lz_blank;
        end
    end

    // A load in the same cycle as a commit wins: its data is still waiting
    // in staging afterwards, so pending must stay set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (load) begin
            pending_q <= 1'b1;
        end else if (commit) begin
            pending_q <= 1'b0;
        end
    end

    //-------------------------------------------------------------------------
    // Display registers
    //-------------------------------------------------------------------------
    // On a load/commit collision this copies the staging contents as they
    // were before the edge, i.e. the previously staged value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_lz_q    <= 1'b0;
        end else if (commit) begin
            disp_value_q <= stg_value_q;
            disp_dp_q    <= stg_dp_q;
            disp_lz_q    <= stg_lz_q;
        end
    end

    //-------------------------------------------------------------------------
    // Hex font, returns segments {A,B,C,D,E,F,G}
    //-------------------------------------------------------------------------
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        f = 7'b0000000;
        case (nib)
            4'h0: f = 7'b1111110;
            4'h1: f = 7'b0110000;
            4'h2: f = 7'b1101101;
            4'h3: f = 7'b1111001;
            4'h4: f = 7'b0110011;
            4'h5: f = 7'b1011011;
            4'h6: f = 7'b1011111;
            4'h7: f = 7'b1110000;
            4'h8: f = 7'b1111111;
            4'h9: f = 7'b1111011;
            4'hA: f = 7'b1110111;
            4'hB: f = 7'b0011111;
            4'hC: f = 7'b1001110;
            4'hD: f = 7'b0111101;
            4'hE: f = 7'b1001111;
            4'hF: f = 7'b1000111;
            default: f = 7'b0000000;
        endcase
        return f;
    endfunction

    //-------------------------------------------------------------------------
    // Encoder with leading-zero blanking
    //-------------------------------------------------------------------------
    // zero_from[k] is set when nibbles k..7 are all zero; it is built from
    // the top digit downwards so each digit only looks at its own nibble and
    // the digit above.
    logic [7:0] zero_from;
    logic [7:0] seg_arr [8];

    // NOTE: every signal written in this always_comb gets a value on every
    // path (defaults first), otherwise synthesis would infer latches.
    always_comb begin
        logic [3:0] nib;
        logic       blank;

        zero_from = '0;
        for (int k = 0; k < 8; k++) begin
            seg_arr[k] = 8'h00;
        end

        zero_from[7] = (disp_value_q[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (disp_value_q[4*k +: 4] == 4'h0);
        end

        for (int k = 0; k < 8; k++) begin
            nib   = disp_value_q[4*k +: 4];
            // Digit 0 always shows, so an all-zero value still reads "0".
            blank = disp_lz_q && (k != 0) && zero_from[k];
            seg_arr[k] = {blank ? 7'b0000000 : hex_font(nib), disp_dp_q[k]};
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign idx        = {1'b0, idx_q};
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

    assign seg0 = seg_arr[0];
    assign seg1 = seg_arr[1];
    assign seg2 = seg_arr[2];
    assign seg3 = seg_arr[3];
    assign seg4 = seg_arr[4];
    assign seg5 = seg_arr[5];
    assign seg6 = seg_arr[6];
    assign seg7 = seg_arr[7];

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
//-----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Self-checking bench for sseg_scan_ctrl with DIV=4. Inputs are driven and
// outputs sampled just after the falling edge; the DUT acts on rising edges.
// Encoding is checked from a table of hand-encoded vectors applied with the
// scan stopped; scan timing, frame-boundary commit, overwrite, load/commit
// collision, enable-low hold and mid-scan reset are hand-written sequences.
//-----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        lz_blank;
    logic [3:0]  idx;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic        frame_done;
    logic        pending;

    logic [63:0] segs;
    assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    int n_pass;
    int n_total;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        logic        lz;
        logic [63:0] exp_segs;   // {seg7..seg0}
    } vec_t;

    vec_t vecs [9];

    sseg_scan_ctrl #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .lz_blank   (lz_blank),
        .idx        (idx),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .seg4       (seg4),
        .seg5       (seg5),
        .seg6       (seg6),
        .seg7       (seg7),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Step until idx newly becomes target (leaving it first if already there).
    task automatic wait_entry(input string name, input logic [3:0] target);
        int budget;
        budget = 0;
        while (idx == target && budget < 100) begin step(); budget++; end
        while (idx != target && budget < 100) begin step(); budget++; end
        check({name, "_reached"}, 64'(budget < 100 && idx == target), 64'd1);
    endtask

    // Present a load for one rising edge.
    task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic lz);
        value    = v;
        dp       = d;
        lz_blank = lz;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    localparam logic [63:0] ALL_FC   = 64'hFCFC_FCFC_FCFC_FCFC;
    localparam logic [63:0] PAT_0123 = 64'hFC60_DAF2_EE3E_9C7A;
    localparam logic [63:0] PAT_2222 = 64'hDADA_DADA_DADA_DADA;
    localparam logic [63:0] PAT_4567 = 64'h67B7_BFE1_FFF7_9F8F;
    localparam logic [63:0] PAT_8001 = 64'hFEFC_FCFC_FCFC_FC60;

    initial begin
        logic [3:0] held_idx;
        int         bad;
        int         budget;

        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{32'h0123_ABCD, 8'h00, 1'b0, PAT_0123};
        vecs[1] = '{32'h0000_0050, 8'h04, 1'b1, 64'h0000_0000_0001_B6FC};
        vecs[2] = '{32'h0000_0000, 8'h00, 1'b1, 64'h0000_0000_0000_00FC};
        vecs[3] = '{32'h4567_89EF, 8'hFF, 1'b0, PAT_4567};
        vecs[4] = '{32'h00A0_0000, 8'h80, 1'b1, 64'h0100_EEFC_FCFC_FCFC};
        vecs[5] = '{32'h8000_0001, 8'h00, 1'b1, PAT_8001};
        vecs[6] = '{32'h2222_2222, 8'h00, 1'b0, PAT_2222};
        vecs[7] = '{32'h0000_000F, 8'h01, 1'b1, 64'h0000_0000_0000_008F};
        vecs[8] = '{32'h0000_0100, 8'h02, 1'b0, 64'hFCFC_FCFC_FC60_FDFC};

        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        lz_blank = 1'b0;

        // ---- Reset state ----
        repeat (3) step();
        check("rst_idx",        64'(idx),        64'd0);
        check("rst_pending",    64'(pending),    64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_segs",       segs,            ALL_FC);

        // ---- Scan rate: idx steps every DIV cycles, frame_done every 8*DIV ----
        rst_n = 1'b1;
        en    = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            step();
            check($sformatf("scan_idx_%0d", n), 64'(idx), 64'((n / DIV) % 8));
            check($sformatf("scan_fd_%0d", n), 64'(frame_done),
                  64'(n % (8 * DIV) == 0));
        end

        // ---- Frame-boundary commit ----
        wait_entry("fb_idx3", 4'd3);
        do_load(32'h0123_ABCD, 8'h00, 1'b0);
        check("fb_pending_set", 64'(pending), 64'd1);
        check("fb_segs_before", segs, ALL_FC);
        wait_entry("fb_idx7", 4'd7);
        check("fb_pending_at7", 64'(pending), 64'd1);
        check("fb_segs_at7", segs, ALL_FC);
        wait_entry("fb_idx0", 4'd0);
        check("fb_segs_after", segs, PAT_0123);
        check("fb_pending_clr", 64'(pending), 64'd0);
        check("fb_frame_done", 64'(frame_done), 64'd1);

        // ---- Overwrite: last load before the boundary wins ----
        wait_entry("ow_idx2", 4'd2);
        do_load(32'h1111_1111, 8'h00, 1'b0);
        wait_entry("ow_idx4", 4'd4);
        do_load(32'h2222_2222, 8'h00, 1'b0);
        wait_entry("ow_idx7", 4'd7);
        check("ow_segs_at7", segs, PAT_0123);
        wait_entry("ow_idx0", 4'd0);
        check("ow_segs_after", segs, PAT_2222);
        check("ow_pending_clr", 64'(pending), 64'd0);

        // ---- Load coincident with the commit edge ----
        wait_entry("col_idx5", 4'd5);
        do_load(32'h4567_89EF, 8'hFF, 1'b0);
        wait_entry("col_idx7", 4'd7);
        repeat (DIV - 1) step();               // now in the tick cycle
        check("col_idx_pre", 64'(idx), 64'd7);
        do_load(32'h8000_0001, 8'h00, 1'b1);   // lands on the 7->0 edge
        check("col_idx_wrap", 64'(idx), 64'd0);
        check("col_segs_old", segs, PAT_4567);
        check("col_pending_kept", 64'(pending), 64'd1);
        wait_entry("col_next0", 4'd0);
        check("col_segs_new", segs, PAT_8001);
        check("col_pending_clr", 64'(pending), 64'd0);

        // ---- Enable low: hold idx/cnt, no frame_done ----
        wait_entry("en_idx2", 4'd2);           // cnt is 0 in this cycle
        en       = 1'b0;
        held_idx = idx;
        bad      = 0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (idx != held_idx || frame_done !== 1'b0) bad++;
        end
        check("en_hold_bad_cycles", 64'(bad), 64'd0);
        check("en_hold_idx", 64'(idx), 64'd2);

        // Encoding table: with en=0 the commit lands on the edge after load.
        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].value, vecs[i].dp, vecs[i].lz);
            check($sformatf("vec%0d_pending_set", i), 64'(pending), 64'd1);
            step();
            check($sformatf("vec%0d_segs", i), segs, vecs[i].exp_segs);
            check($sformatf("vec%0d_pending_clr", i), 64'(pending), 64'd0);
        end
        check("en_hold_idx_after_loads", 64'(idx), 64'd2);

        // Resume from the held idx with cnt still at 0.
        en = 1'b1;
        repeat (DIV - 1) step();
        check("resume_idx_held", 64'(idx), 64'd2);
        step();
        check("resume_idx_next", 64'(idx), 64'd3);

        // ---- Mid-scan reset with data pending ----
        wait_entry("mr_idx5", 4'd5);
        step();
        do_load(32'h1234_5678, 8'hAA, 1'b0);
        check("mr_pending_set", 64'(pending), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mr_idx", 64'(idx), 64'd0);
        check("mr_pending", 64'(pending), 64'd0);
        check("mr_frame_done", 64'(frame_done), 64'd0);
        check("mr_segs", segs, ALL_FC);
        repeat (3) step();
        check("mr_held_idx", 64'(idx), 64'd0);
        rst_n = 1'b1;
        repeat (DIV - 1) step();
        check("mr_resume_idx0", 64'(idx), 64'd0);
        step();
        check("mr_resume_idx1", 64'(idx), 64'd1);
        budget = 0;
        wait_entry("mr_next0", 4'd0);
        check("mr_staged_lost_segs", segs, ALL_FC);
        check("mr_staged_lost_pending", 64'(pending), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
